// File: rtl/regfile_mp.sv
// regfile_mp: 2-write/2-read register file with optional bypass, sync clear and pending scoreboard (ports: clk, rst, rn1/rn2 -> rd1/rd2 + rd1_pend/rd2_pend, we0/wn0/wd0 and we1/wn1/wd1 writes, iss/iss_rn reservations)
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter bit          BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rn1,
  input  logic [ADDR_W-1:0] rn2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_pend,
  output logic              rd2_pend,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wn0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wn1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              iss,
  input  logic [ADDR_W-1:0] iss_rn
);
  logic [DATA_W-1:0] regs [1:NUM_REGS-1];
  logic [NUM_REGS-1:1] pend;
  logic [ADDR_W-1:0] rn [2];
  logic [DATA_W-1:0] rd [2];
  logic rp [2];
  always_ff @(posedge clk)
    for (int i = 1; i < NUM_REGS; i++) begin
      regs[i] <= rst ? '0 : (we1 && wn1 == ADDR_W'(i)) ? wd1 : (we0 && wn0 == ADDR_W'(i)) ? wd0 : regs[i];
      pend[i] <= rst ? 1'b0 : (iss && iss_rn == ADDR_W'(i)) ? 1'b1 :
                 ((we0 && wn0 == ADDR_W'(i)) || (we1 && wn1 == ADDR_W'(i))) ? 1'b0 : pend[i];
    end
  assign rn[0] = rn1;
  assign rn[1] = rn2;
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [DATA_W-1:0] q;
    logic sp, sel, h0, h1;
    always_comb begin
      q = '0;
      sp = 1'b0;
      sel = 1'b0;
      for (int i = 1; i < NUM_REGS; i++)
        if (rn[p] == ADDR_W'(i)) begin
          q = regs[i];
          sp = pend[i];
          sel = 1'b1;
        end
    end
    assign h1 = BYPASS && !rst && sel && we1 && wn1 == rn[p];
    assign h0 = BYPASS && !rst && sel && we0 && wn0 == rn[p];
    assign rd[p] = h1 ? wd1 : h0 ? wd0 : q;
    assign rp[p] = sp && !(h0 || h1);
  end
  assign rd1 = rd[0];
  assign rd2 = rd[1];
  assign rd1_pend = rp[0];
  assign rd2_pend = rp[1];
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed check of three regfile_mp configurations against a behavioural model
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rst, we0, we1, iss;
  logic [4:0] rn1, rn2, wn0, wn1, iss_rn;
  logic [31:0] wd0, wd1;
  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic [15:0] c_rd1, c_rd2;
  logic a_p1, a_p2, b_p1, b_p2, c_p1, c_p2;
  int errors = 0, checks = 0;
  bit en = 0;
  logic [31:0] m_reg [3][32];
  bit m_pend [3][32];
  int nr [3] = '{32, 32, 8};
  bit bp [3] = '{1, 0, 1};
  logic [31:0] msk [3] = '{32'hffffffff, 32'hffffffff, 32'h0000ffff};
  always #5 clk = ~clk;
  regfile_mp u_a (.clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .rd1(a_rd1), .rd2(a_rd2),
    .rd1_pend(a_p1), .rd2_pend(a_p2), .we0(we0), .wn0(wn0), .wd0(wd0), .we1(we1), .wn1(wn1),
    .wd1(wd1), .iss(iss), .iss_rn(iss_rn));
  regfile_mp #(.BYPASS(0)) u_b (.clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .rd1(b_rd1), .rd2(b_rd2),
    .rd1_pend(b_p1), .rd2_pend(b_p2), .we0(we0), .wn0(wn0), .wd0(wd0), .we1(we1), .wn1(wn1),
    .wd1(wd1), .iss(iss), .iss_rn(iss_rn));
  regfile_mp #(.DATA_W(16), .NUM_REGS(8)) u_c (.clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .rd1(c_rd1),
    .rd2(c_rd2), .rd1_pend(c_p1), .rd2_pend(c_p2), .we0(we0), .wn0(wn0), .wd0(wd0[15:0]), .we1(we1),
    .wn1(wn1), .wd1(wd1[15:0]), .iss(iss), .iss_rn(iss_rn));
  function automatic bit ok(int k, logic [4:0] a);
    return a != 0 && int'(a) < nr[k];
  endfunction
  function automatic logic [31:0] e_rd(int k, logic [4:0] a);
    if (!ok(k, a)) return 32'h0;
    if (bp[k] && !rst && we1 && wn1 == a) return wd1 & msk[k];
    if (bp[k] && !rst && we0 && wn0 == a) return wd0 & msk[k];
    return m_reg[k][a];
  endfunction
  function automatic logic [31:0] e_pend(int k, logic [4:0] a);
    bit fwd;
    fwd = bp[k] && !rst && ((we0 && wn0 == a) || (we1 && wn1 == a));
    return {31'h0, ok(k, a) && m_pend[k][a] && !fwd};
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask
  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (rst) begin
        for (int i = 0; i < 32; i++) begin
          m_reg[k][i] <= 32'h0;
          m_pend[k][i] <= 1'b0;
        end
      end else begin
        if (we0 && ok(k, wn0)) begin
          m_reg[k][wn0] <= wd0 & msk[k];
          m_pend[k][wn0] <= 1'b0;
        end
        if (we1 && ok(k, wn1)) begin
          m_reg[k][wn1] <= wd1 & msk[k];
          m_pend[k][wn1] <= 1'b0;
        end
        if (iss && ok(k, iss_rn)) m_pend[k][iss_rn] <= 1'b1;
      end
  always @(negedge clk)
    if (en) begin
      chk("A.rd1", a_rd1, e_rd(0, rn1));
      chk("A.rd2", a_rd2, e_rd(0, rn2));
      chk("A.pend1", 32'(a_p1), e_pend(0, rn1));
      chk("A.pend2", 32'(a_p2), e_pend(0, rn2));
      chk("B.rd1", b_rd1, e_rd(1, rn1));
      chk("B.rd2", b_rd2, e_rd(1, rn2));
      chk("B.pend1", 32'(b_p1), e_pend(1, rn1));
      chk("B.pend2", 32'(b_p2), e_pend(1, rn2));
      chk("C.rd1", {16'h0, c_rd1}, e_rd(2, rn1));
      chk("C.rd2", {16'h0, c_rd2}, e_rd(2, rn2));
      chk("C.pend1", 32'(c_p1), e_pend(2, rn1));
      chk("C.pend2", 32'(c_p2), e_pend(2, rn2));
    end
  task automatic idle();
    rst = 0; we0 = 0; we1 = 0; iss = 0;
    wn0 = 0; wn1 = 0; iss_rn = 0; wd0 = 0; wd1 = 0;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [4:0] pick();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
  endfunction
  initial begin
    idle();
    rst = 1; rn1 = 0; rn2 = 0;
    nxt(); nxt();
    idle(); en = 1;
    we0 = 1; wn0 = 5; wd0 = 32'hDEADBEEF;
    nxt(); idle(); rn1 = 5;
    @(negedge clk); chk("lit.r5_written", a_rd1, 32'hDEADBEEF);
    nxt(); rst = 1; we0 = 1; wn0 = 6; wd0 = 32'h1234; rn1 = 5; rn2 = 6;
    @(negedge clk); chk("lit.rst_shows_stored", a_rd1, 32'hDEADBEEF); chk("lit.rst_no_fwd", a_rd2, 32'h0);
    nxt(); idle(); rn1 = 5; rn2 = 6;
    @(negedge clk); chk("lit.rst_r5", a_rd1, 0); chk("lit.rst_r6", a_rd2, 0);
    chk("lit.rst_pend", {a_p1, a_p2}, 0);
    nxt(); we0 = 1; wn0 = 0; wd0 = 32'hFFFFFFFF; iss = 1; iss_rn = 0; rn1 = 0;
    @(negedge clk); chk("lit.r0_rd", a_rd1, 0); chk("lit.r0_pend", 32'(a_p1), 0);
    nxt();
    @(negedge clk); chk("lit.r0_rd_next", a_rd1, 0); chk("lit.r0_pend_next", 32'(a_p1), 0);
    nxt(); idle(); we0 = 1; wn0 = 7; wd0 = 32'h11; we1 = 1; wn1 = 7; wd1 = 32'h22; rn1 = 7;
    @(negedge clk); chk("lit.coll_fwd", a_rd1, 32'h22); chk("lit.coll_nofwd", b_rd1, 0);
    nxt(); idle(); rn1 = 7;
    @(negedge clk); chk("lit.coll_A", a_rd1, 32'h22); chk("lit.coll_B", b_rd1, 32'h22);
    chk("lit.coll_C", 32'(c_rd1), 32'h22);
    nxt(); we0 = 1; wn0 = 3; wd0 = 32'hA;
    nxt(); we0 = 1; wn0 = 3; wd0 = 32'hB; rn1 = 3; rn2 = 3;
    @(negedge clk); chk("lit.byp_A1", a_rd1, 32'hB); chk("lit.byp_A2", a_rd2, 32'hB);
    chk("lit.byp_B1", b_rd1, 32'hA); chk("lit.byp_B2", b_rd2, 32'hA);
    nxt(); idle(); rn1 = 3;
    @(negedge clk); chk("lit.byp_B_next", b_rd1, 32'hB);
    nxt(); iss = 1; iss_rn = 9; rn1 = 9;
    @(negedge clk); chk("lit.iss_same", 32'(a_p1), 0);
    nxt(); idle(); rn1 = 9;
    @(negedge clk); chk("lit.iss_next_A", 32'(a_p1), 1); chk("lit.iss_next_B", 32'(b_p1), 1);
    nxt(); we1 = 1; wn1 = 9; wd1 = 32'h55; rn1 = 9;
    @(negedge clk); chk("lit.sb_A_pend", 32'(a_p1), 0); chk("lit.sb_A_rd", a_rd1, 32'h55);
    chk("lit.sb_B_pend", 32'(b_p1), 1); chk("lit.sb_B_rd", b_rd1, 0);
    nxt(); idle(); rn1 = 9;
    @(negedge clk); chk("lit.sb_A_after", {a_p1, a_rd1}, {1'b0, 32'h55});
    chk("lit.sb_B_after", {b_p1, b_rd1}, {1'b0, 32'h55});
    nxt(); iss = 1; iss_rn = 4; we0 = 1; wn0 = 4; wd0 = 32'h77;
    nxt(); idle(); rn1 = 4;
    @(negedge clk); chk("lit.setwins_A", 32'(a_p1), 1); chk("lit.setwins_B", 32'(b_p1), 1);
    nxt(); we0 = 1; wn0 = 12; wd0 = 32'hBEEF; iss = 1; iss_rn = 12; rn1 = 12;
    @(negedge clk); chk("lit.C_oor_fwd", 32'(c_rd1), 0);
    nxt(); idle(); rn1 = 12;
    @(negedge clk); chk("lit.C_oor_rd", 32'(c_rd1), 0); chk("lit.C_oor_pend", 32'(c_p1), 0);
    chk("lit.A_r12", a_rd1, 32'hBEEF);
    repeat (3000) begin
      nxt();
      rst = $urandom_range(0, 99) == 0;
      we0 = $urandom_range(0, 1) == 1; wn0 = pick(); wd0 = $urandom;
      we1 = $urandom_range(0, 2) == 0; wn1 = ($urandom_range(0, 3) == 0) ? wn0 : pick(); wd1 = $urandom;
      iss = $urandom_range(0, 1) == 1; iss_rn = ($urandom_range(0, 3) == 0) ? wn0 : pick();
      rn1 = ($urandom_range(0, 2) == 0) ? wn0 : pick();
      rn2 = ($urandom_range(0, 2) == 0) ? wn1 : pick();
    end
    nxt();
    en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
